// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: command, ALU-drive and result signals of the ALU
// command sequencer. The master view belongs to the sequencer. The slave
// view belongs to whatever sits on the other side: the command producer,
// the ALU and the result consumer.
interface alu_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       alu_on;
  logic [2:0] alu_in_sel;
  logic [7:0] alu_num1;
  logic [7:0] alu_num2;
  logic [6:0] alu_out_sel;
  logic [7:0] alu_out;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [6:0] res_op;
  logic       err;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, res_ready,
    output cmd_ready, alu_on, alu_in_sel, alu_num1, alu_num2, alu_out_sel,
           res_valid, res_data, res_op, err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, res_ready,
    input  cmd_ready, alu_on, alu_in_sel, alu_num1, alu_num2, alu_out_sel,
           res_valid, res_data, res_op, err
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers {op, a, b} commands in a small FIFO and plays
// them into the 8-bit ALU one at a time. Each command is loaded for a single
// cycle, the fixed ALU latency is waited out, and the captured result is held
// on a valid/ready port until it is taken. Illegal (non-one-hot) ops are
// dropped and raise a sticky error flag.
module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 2
) (
  input logic                 clk,
  input logic                 rst,
  alu_cmd_sequencer_if.master bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(DEPTH);
  localparam logic [LAT_W-1:0] LAT_INIT    = LAT_W'(ALU_LAT - 1);
  localparam logic [2:0]       SEL_RESET   = 3'b001;
  localparam logic [2:0]       SEL_LOAD    = 3'b010;
  localparam logic [2:0]       SEL_PERSIST = 3'b100;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  logic [22:0]      fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_t           state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [6:0]       op_q, op_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic [2:0]       in_sel_q, in_sel_d;
  logic             on_q, on_d;
  logic [7:0]       res_data_q, res_data_d;
  logic [6:0]       res_op_q, res_op_d;
  logic             err_q, err_d;
  logic             push, pop;
  logic [6:0]       head_op;
  logic [7:0]       head_a, head_b;
  logic             head_legal;

  assign bus.cmd_ready   = (count_q != FULL_CNT);
  assign bus.alu_on      = on_q;
  assign bus.alu_in_sel  = in_sel_q;
  assign bus.alu_num1    = a_q;
  assign bus.alu_num2    = b_q;
  assign bus.alu_out_sel = op_q;
  assign bus.res_valid   = (state_q == HOLD);
  assign bus.res_data    = res_data_q;
  assign bus.res_op      = res_op_q;
  assign bus.err         = err_q;

  // FIFO bookkeeping: pushes gated by cmd_ready, pops only by an idle FSM
  always_comb begin
    push       = bus.cmd_valid && bus.cmd_ready;
    pop        = (state_q == IDLE) && (count_q != '0);
    {head_op, head_a, head_b} = fifo_mem[rd_ptr_q];
    head_legal = (head_op != '0) && ((head_op & (head_op - 7'd1)) == '0);
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Command FSM: pop/validate, one load cycle, latency wait, result hold
  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    res_data_d = res_data_q;
    res_op_d   = res_op_q;
    err_d      = err_q;
    on_d       = 1'b1;
    case (state_q)
      IDLE: begin
        if (pop) begin
          if (head_legal) begin
            op_d    = head_op;
            a_d     = head_a;
            b_d     = head_b;
            state_d = ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        lat_d   = LAT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q == '0) begin
          res_data_d = bus.alu_out;
          res_op_d   = op_q;
          state_d    = HOLD;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      HOLD: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_sel_d = (state_d == ISSUE) ? SEL_LOAD : SEL_PERSIST;
  end

  // State and output registers, all cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      lat_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      in_sel_q   <= SEL_RESET;
      on_q       <= 1'b0;
      res_data_q <= '0;
      res_op_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      lat_q      <= lat_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      in_sel_q   <= in_sel_d;
      on_q       <= on_d;
      res_data_q <= res_data_d;
      res_op_q   <= res_op_d;
      err_q      <= err_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: drives three sequencers (ALU_LAT 2, 1, 4) from one
// shared command stream, each with its own stand-in ALU. Results of the
// ALU_LAT=2 instance are scored against a queue-based reference model.
module tb_alu_cmd_sequencer;
  localparam int NUM_INST = 3;

  typedef struct packed {
    logic [6:0] op;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [6:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_data;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [6:0] cmd_op = '0;
  logic [7:0] cmd_a = '0;
  logic [7:0] cmd_b = '0;
  logic       res_ready = 1'b0;

  wire [NUM_INST-1:0]       cmd_ready_v, alu_on_v, res_valid_v, err_v;
  wire [NUM_INST-1:0][2:0]  in_sel_v;
  wire [NUM_INST-1:0][7:0]  num1_v, num2_v, res_data_v;
  wire [NUM_INST-1:0][6:0]  out_sel_v, res_op_v;
  wire [NUM_INST-1:0][15:0] load_cnt_v;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q [$];
  vec_t vec_tbl [5];
  int   first_seen [NUM_INST];
  logic [NUM_INST-1:0][15:0] base_loads;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = '0;
  logic [6:0] prev_op = '0;

  function automatic int latOf(input int idx);
    return (idx == 0) ? 2 : ((idx == 1) ? 1 : 4);
  endfunction

  function automatic logic [7:0] aluFunc(input logic [6:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      7'b1000000: return a + b;
      7'b0100000: return a - b;
      7'b0010000: return a & b;
      7'b0001000: return a | b;
      7'b0000100: return a ^ b;
      7'b0000010: return ~a;
      7'b0000001: return a;
      default:    return 8'h00;
    endcase
  endfunction

  always #5 clk = ~clk;

  for (genvar g = 0; g < NUM_INST; g++) begin : g_inst
    localparam int LAT = latOf(g);
    alu_cmd_sequencer_if bus ();
    logic [3:0]  alu_age;
    logic [7:0]  alu_val;
    logic [15:0] load_cnt;

    assign bus.cmd_valid = cmd_valid;
    assign bus.cmd_op    = cmd_op;
    assign bus.cmd_a     = cmd_a;
    assign bus.cmd_b     = cmd_b;
    assign bus.res_ready = res_ready;
    // Stand-in ALU: the true result shows up LAT cycles after the load cycle, its inverse before that
    assign bus.alu_out   = (alu_age >= 4'(LAT) && bus.alu_in_sel != 3'b010) ? alu_val : ~alu_val;

    // Stand-in ALU state: latch operands on a load, then age the result
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        alu_age  <= '0;
        alu_val  <= '0;
        load_cnt <= '0;
      end else if (bus.alu_in_sel == 3'b010) begin
        alu_age  <= 4'd1;
        alu_val  <= aluFunc(bus.alu_out_sel, bus.alu_num1, bus.alu_num2);
        load_cnt <= load_cnt + 16'd1;
      end else if (alu_age != 4'd0 && alu_age != 4'hF) begin
        alu_age <= alu_age + 4'd1;
      end
    end

    assign cmd_ready_v[g] = bus.cmd_ready;
    assign alu_on_v[g]    = bus.alu_on;
    assign res_valid_v[g] = bus.res_valid;
    assign err_v[g]       = bus.err;
    assign in_sel_v[g]    = bus.alu_in_sel;
    assign num1_v[g]      = bus.alu_num1;
    assign num2_v[g]      = bus.alu_num2;
    assign res_data_v[g]  = bus.res_data;
    assign out_sel_v[g]   = bus.alu_out_sel;
    assign res_op_v[g]    = bus.res_op;
    assign load_cnt_v[g]  = load_cnt;

    alu_cmd_sequencer #(.DEPTH(4), .ALU_LAT(LAT)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command and hold it until accepted; the model queues legal ones
  task automatic applyStimulus(input logic [6:0] op, input logic [7:0] a, input logic [7:0] b);
    int waited = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    @(negedge clk);
    while (!cmd_ready_v[0] && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("push_accept", 32'(cmd_ready_v[0]), 32'd1);
    if (cmd_ready_v[0] && $countones(op) == 1) begin
      exp_q.push_back({op, aluFunc(op, a, b)});
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((exp_q.size() != 0 || res_valid_v[0]) && n < 400) begin
      tick();
      n++;
    end
    checkOutput("drain_pending", 32'(exp_q.size()), 32'd0);
    repeat (10) tick();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cmd_ready"}, 32'(cmd_ready_v[0]), 32'd1);
    checkOutput({tag, "_alu_on"}, 32'(alu_on_v[0]), 32'd0);
    checkOutput({tag, "_in_sel"}, 32'(in_sel_v[0]), 32'h1);
    checkOutput({tag, "_num1"}, 32'(num1_v[0]), 32'd0);
    checkOutput({tag, "_num2"}, 32'(num2_v[0]), 32'd0);
    checkOutput({tag, "_out_sel"}, 32'(out_sel_v[0]), 32'd0);
    checkOutput({tag, "_res_data"}, 32'(res_data_v[0]), 32'd0);
    checkOutput({tag, "_res_op"}, 32'(res_op_v[0]), 32'd0);
    checkOutput({tag, "_res_valid"}, 32'(res_valid_v[0]), 32'd0);
    checkOutput({tag, "_err"}, 32'(err_v[0]), 32'd0);
  endtask

  // Result scoreboard for the ALU_LAT=2 instance, plus hold-stability of the result
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && res_valid_v[0]) begin
        checkOutput("hold_data_stable", 32'(res_data_v[0]), 32'(prev_data));
        checkOutput("hold_op_stable", 32'(res_op_v[0]), 32'(prev_op));
      end
      if (res_valid_v[0] && res_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_result: actual data 0x%0h op 0x%0h, required no result", res_data_v[0], res_op_v[0]);
        end else begin
          e = exp_q.pop_front();
          checkOutput("res_data", 32'(res_data_v[0]), 32'(e.data));
          checkOutput("res_op", 32'(res_op_v[0]), 32'(e.op));
        end
      end
      prev_hold = res_valid_v[0] && !res_ready;
      prev_data = res_data_v[0];
      prev_op   = res_op_v[0];
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    vec_tbl[0] = '{7'b1000000, 8'h57, 8'h1A, 8'h71};
    vec_tbl[1] = '{7'b0100000, 8'h50, 8'h13, 8'h3D};
    vec_tbl[2] = '{7'b0010000, 8'hF0, 8'h3C, 8'h30};
    vec_tbl[3] = '{7'b0001000, 8'h0F, 8'hA0, 8'hAF};
    vec_tbl[4] = '{7'b0000100, 8'hFF, 8'h5A, 8'hA5};

    // Reset state and release
    #12;
    checkResetValues("por");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("por_on_before_edge", 32'(alu_on_v[0]), 32'd0);
    @(negedge clk);
    checkOutput("por_on_after_edge", 32'(alu_on_v[0]), 32'd1);
    checkOutput("por_in_sel_persist", 32'(in_sel_v[0]), 32'h4);
    tick();

    // Single add on all three latencies: load width, result timing, value
    $display("[TB] single add / latency");
    res_ready  = 1'b0;
    base_loads = load_cnt_v;
    for (int g = 0; g < NUM_INST; g++) first_seen[g] = -1;
    applyStimulus(7'b1000000, 8'h57, 8'h1A);
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      for (int g = 0; g < NUM_INST; g++) begin
        if (first_seen[g] < 0 && res_valid_v[g]) first_seen[g] = j;
      end
    end
    for (int g = 0; g < NUM_INST; g++) begin
      checkOutput($sformatf("valid_edge_lat%0d", latOf(g)), 32'(first_seen[g]), 32'(2 + latOf(g)));
      checkOutput($sformatf("add_data_lat%0d", latOf(g)), 32'(res_data_v[g]), 32'h71);
      checkOutput($sformatf("add_op_lat%0d", latOf(g)), 32'(res_op_v[g]), 32'h40);
      checkOutput($sformatf("load_cycles_lat%0d", latOf(g)), 32'(load_cnt_v[g] - base_loads[g]), 32'd1);
    end
    tick();
    res_ready = 1'b1;
    waitDrain();

    // Back-pressure: five commands with the consumer stalled
    $display("[TB] back-pressure");
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(vec_tbl[i].op, vec_tbl[i].a, vec_tbl[i].b);
    @(negedge clk);
    checkOutput("bp_cmd_ready_full", 32'(cmd_ready_v[0]), 32'd0);
    repeat (6) @(negedge clk);
    checkOutput("bp_still_full", 32'(cmd_ready_v[0]), 32'd0);
    checkOutput("bp_valid_held", 32'(res_valid_v[0]), 32'd1);
    checkOutput("bp_data_held", 32'(res_data_v[0]), 32'(vec_tbl[0].exp_data));
    tick();
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      int n = 0;
      @(negedge clk);
      while (!res_valid_v[0] && n < 50) begin
        @(negedge clk);
        n++;
      end
      checkOutput($sformatf("bp_valid_%0d", i), 32'(res_valid_v[0]), 32'd1);
      checkOutput($sformatf("bp_data_%0d", i), 32'(res_data_v[0]), 32'(vec_tbl[i].exp_data));
      checkOutput($sformatf("bp_op_%0d", i), 32'(res_op_v[0]), 32'(vec_tbl[i].op));
      tick();
    end
    waitDrain();

    // Illegal op followed by a legal add
    $display("[TB] illegal op");
    checkOutput("err_before_illegal", 32'(err_v[0]), 32'd0);
    applyStimulus(7'b0000011, 8'h11, 8'h22);
    applyStimulus(7'b1000000, 8'h02, 8'h04);
    waitDrain();
    checkOutput("err_sticky", 32'(err_v[0]), 32'd1);
    checkOutput("illegal_last_data", 32'(res_data_v[0]), 32'h06);

    // Reset asserted while a command is waiting on the ALU
    $display("[TB] reset mid-wait");
    applyStimulus(7'b0100000, 8'h90, 8'h10);
    tick();
    tick();
    checkOutput("midwait_in_sel", 32'(in_sel_v[0]), 32'h4);
    checkOutput("midwait_num1", 32'(num1_v[0]), 32'h90);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    checkResetValues("midwait");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rel_on_before_edge", 32'(alu_on_v[0]), 32'd0);
    @(negedge clk);
    checkOutput("rel_on_after_edge", 32'(alu_on_v[0]), 32'd1);
    checkOutput("rel_cmd_ready", 32'(cmd_ready_v[0]), 32'd1);
    checkOutput("rel_res_valid", 32'(res_valid_v[0]), 32'd0);
    tick();

    // Random commands with gaps, enough to wrap the FIFO pointers twice
    $display("[TB] random wrap-around");
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      applyStimulus(7'(1 << $urandom_range(0, 6)), 8'($urandom), 8'($urandom));
    end
    waitDrain();
    checkOutput("final_err_clear", 32'(err_v[0]), 32'd0);
    checkOutput("final_cmd_ready", 32'(cmd_ready_v[0]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
